// File: rtl/aff_pkg.sv
// aff_pkg: constants shared by the display scanner and the BCD-to-7-segment decoder.
//   BCD_MAX     largest legal BCD digit value
//   ACTIVE_LOW  select/segment polarity code for active-low outputs
//   ACTIVE_HIGH select/segment polarity code for active-high outputs
package aff_pkg;

    localparam int BCD_MAX     = 9;
    localparam int ACTIVE_LOW  = 0;
    localparam int ACTIVE_HIGH = 1;

    // A digit outside 0..BCD_MAX is shown as 0 rather than driving the decoder with garbage.
    function automatic logic [3:0] bcd_clean(input logic [3:0] d);
        return (d > 4'(BCD_MAX)) ? 4'd0 : d;
    endfunction

endpackage

// File: rtl/aff_scan_tick.sv
// aff_scan_tick: digit-slot prescaler, counts 0..SCAN_DIV-1 and flags the last cycle of a slot.
//   clk_i   system clock
//   rst_i   synchronous active-high reset
//   cnt_o   current position inside the slot
//   wrap_o  high while cnt_o == SCAN_DIV-1 (the next edge starts a new slot)
module aff_scan_tick #(
    parameter int SCAN_DIV = 50000
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    output logic [$clog2(SCAN_DIV)-1:0] cnt_o,
    output logic                        wrap_o
);

    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        wrap_o = (cnt_q == CW'(SCAN_DIV - 1));
        cnt_d  = wrap_o ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/aff_scan_bcd.sv
// aff_scan_bcd: multiplexed BCD display scanner feeding one shared 7-segment decoder.
//   clk_i     system clock
//   rst_i     synchronous active-high reset (priority over load_i)
//   load_i    single-cycle strobe latching digits_i into the shadow register
//   digits_i  packed BCD, digit 0 in [3:0]
//   byte_o    BCD of the digit in the current slot (0 when blanked)
//   sel_o     one-hot digit select, polarity set by SEL_POLARITY
//   blank_o   current slot is a blanked leading zero
//   err_o     last load contained a digit > 9
module aff_scan_bcd
    import aff_pkg::*;
#(
    parameter int NB_DIGITS    = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD        = 2,
    parameter int BLANK_ZEROS  = 1,
    parameter int SEL_POLARITY = ACTIVE_LOW
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load_i,
    input  logic [4*NB_DIGITS-1:0] digits_i,
    output logic [3:0]             byte_o,
    output logic [NB_DIGITS-1:0]   sel_o,
    output logic                   blank_o,
    output logic                   err_o
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (NB_DIGITS > 1) ? $clog2(NB_DIGITS) : 1;
    // XOR mask that turns an active-high one-hot into the configured polarity; also the idle value.
    localparam logic [NB_DIGITS-1:0] SEL_IDLE = {NB_DIGITS{SEL_POLARITY == ACTIVE_LOW}};

    logic [CW-1:0]          cnt;
    logic                   wrap;
    logic [IW-1:0]          idx_q, idx_d;
    logic [4*NB_DIGITS-1:0] shadow_q, shadow_d, clean;
    logic                   err_q, err_d, bad;
    logic [3:0]             byte_q, byte_d;
    logic [NB_DIGITS-1:0]   sel_q, sel_d, act;
    logic                   blank_q, blank_d, zero_above;

    aff_scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .cnt_o  (cnt),
        .wrap_o (wrap)
    );

    always_comb begin
        clean = '0;
        bad   = 1'b0;
        for (int i = 0; i < NB_DIGITS; i++) begin
            clean[4*i +: 4] = bcd_clean(digits_i[4*i +: 4]);
            bad = bad | (digits_i[4*i +: 4] > 4'(BCD_MAX));
        end
        shadow_d = load_i ? clean : shadow_q;
        err_d    = load_i ? bad : err_q;
        idx_d    = !wrap ? idx_q : (idx_q == IW'(NB_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    // Outputs are computed from the current state and registered, giving one cycle of latency.
    // A digit is blanked when it and every more-significant digit are zero; digit 0 never is.
    always_comb begin
        zero_above = 1'b1;
        blank_d    = 1'b0;
        for (int i = NB_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (shadow_q[4*i +: 4] == 4'd0);
            if (idx_q == IW'(i)) blank_d = zero_above & (BLANK_ZEROS != 0);
        end
        byte_d = blank_d ? 4'd0 : shadow_q[4*idx_q +: 4];
        act    = (!blank_d && cnt >= CW'(GUARD)) ? NB_DIGITS'(1) << idx_q : '0;
        sel_d  = act ^ SEL_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q    <= '0;
            shadow_q <= '0;
            err_q    <= 1'b0;
            byte_q   <= 4'd0;
            sel_q    <= SEL_IDLE;
            blank_q  <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            err_q    <= err_d;
            byte_q   <= byte_d;
            sel_q    <= sel_d;
            blank_q  <= blank_d;
        end
    end

    assign byte_o  = byte_q;
    assign sel_o   = sel_q;
    assign blank_o = blank_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_aff_scan_bcd.sv
// tb_aff_scan_bcd: scoreboard bench for aff_scan_bcd against a time-based reference model.
module tb_aff_scan_bcd;

    localparam int N   = 4;
    localparam int DIV = 8;
    localparam int G   = 2;

    typedef struct {
        logic [3:0]   b;
        logic [N-1:0] s;
        logic         bl;
        logic         e;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           load = 1'b0;
    logic [4*N-1:0] digits = '0;
    logic [3:0]     byte_o;
    logic [N-1:0]   sel_o;
    logic           blank_o;
    logic           err_o;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Model state: cycles since reset release, shadow digits, error flag.
    int   t = 0;
    int   sh[N];
    bit   err_m = 0;

    aff_scan_bcd #(
        .NB_DIGITS(N), .SCAN_DIV(DIV), .GUARD(G), .BLANK_ZEROS(1), .SEL_POLARITY(0)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .load_i   (load),
        .digits_i (digits),
        .byte_o   (byte_o),
        .sel_o    (sel_o),
        .blank_o  (blank_o),
        .err_o    (err_o)
    );

    always #5 clk = ~clk;

    // Reference model: at each edge predict the registered outputs from the pre-edge state.
    initial begin
        foreach (sh[i]) sh[i] = 0;
        forever begin
            @(posedge clk);
            begin
                exp_t x;
                if (rst) begin
                    t = 0;
                    foreach (sh[i]) sh[i] = 0;
                    err_m = 0;
                    x.b = 0; x.s = '1; x.bl = 0; x.e = 0;
                end else begin
                    int  slot_pos, digit;
                    bit  all_zero;
                    slot_pos = t % DIV;
                    digit    = (t / DIV) % N;
                    all_zero = 1;
                    for (int j = digit; j < N; j++) if (sh[j] != 0) all_zero = 0;
                    x.bl = (digit != 0) && all_zero;
                    x.b  = x.bl ? 4'd0 : 4'(sh[digit]);
                    x.s  = '1;
                    if (!x.bl && slot_pos >= G) x.s[digit] = 1'b0;
                    t++;
                    if (load) begin
                        err_m = 0;
                        for (int j = 0; j < N; j++) begin
                            int v;
                            v = int'(digits[4*j +: 4]);
                            if (v > 9) begin
                                err_m = 1;
                                v = 0;
                            end
                            sh[j] = v;
                        end
                    end
                    x.e = err_m;
                end
                q.push_back(x);
            end
        end
    end

    // Monitor: one output vector per cycle, compared away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                exp_t x;
                x = q.pop_front();
                vectors++;
                if (byte_o !== x.b || sel_o !== x.s || blank_o !== x.bl || err_o !== x.e) begin
                    miscompares++;
                    $display("FAIL vec%0d t=%0t: byte/sel/blank/err got %h/%b/%b/%b want %h/%b/%b/%b",
                             vectors, $time, byte_o, sel_o, blank_o, err_o, x.b, x.s, x.bl, x.e);
                end
            end
        end
    end

    task automatic pulse_load(input logic [4*N-1:0] d);
        digits = d;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    function automatic logic [4*N-1:0] rand_digits();
        logic [4*N-1:0] d;
        for (int j = 0; j < N; j++) begin
            int r;
            r = $urandom_range(0, 5);
            d[4*j +: 4] = (r < 2) ? 4'd0 : (r == 2) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        end
        return d;
    endfunction

    // Bounded wait until the next edge will sample the given slot position and digit.
    task automatic wait_pos(input int c, input int d);
        bit hit;
        hit = 0;
        for (int k = 0; k < 4 * N * DIV && !hit; k++) begin
            @(negedge clk);
            hit = (t % DIV == c) && ((t / DIV) % N == d);
        end
        if (!hit) begin
            miscompares++;
            $display("FAIL wait_pos: slot position %0d/digit %0d not reached, required within %0d cycles",
                     c, d, 4 * N * DIV);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2 * N * DIV) @(negedge clk);
        pulse_load(16'h1234);
        repeat (N * DIV + 5) @(negedge clk);
        pulse_load(16'h0045);
        repeat (N * DIV + 3) @(negedge clk);
        pulse_load(16'h12F4);
        repeat (N * DIV) @(negedge clk);
        pulse_load(16'h0000);
        repeat (5) @(negedge clk);
        pulse_load(16'h1234);
        wait_pos(4, 1);
        pulse_load(16'h5678);
        wait_pos(7, 0);
        pulse_load(16'h0300);
        wait_pos(3, 2);
        rst  = 1'b1;
        pulse_load(16'h9999);
        rst  = 1'b0;
        repeat (N * DIV) @(negedge clk);
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                digits = rand_digits();
                load   = 1'b1;
            end else begin
                load   = 1'b0;
            end
            rst = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        rst  = 1'b0;
        load = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
